// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute-stage ALU (master) and the
// iterative divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             data_ok;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;

  modport master (
    output valid, is_signed, a, b,
    input  data_ok, quot, rem, busy
  );

  modport slave (
    input  valid, is_signed, a, b,
    output data_ok, quot, rem, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// Responds to a held valid with a single-cycle data_ok carrying quot/rem.
//
// state | meaning
// IDLE  | waiting for valid; latches operand magnitudes and signs
// BUSY  | iterating, one quotient bit per edge, MSB first
// DONE  | data_ok high for one cycle, then back to IDLE
module seq_divider #(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          resetn,
  seq_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH:0]   rem_p;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             data_ok_r;
  logic             busy_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] sub;
  logic             ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;

  // Borrow out of the widened subtract doubles as the restore decision.
  always_comb begin
    a_mag    = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag    = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    shifted  = {rem_p, dividend[WIDTH-1]};
    sub      = shifted - {2'b00, divisor};
    ge       = ~sub[WIDTH+1];
    rem_next = ge ? sub[WIDTH:0] : shifted[WIDTH:0];
    q_next   = {dividend[WIDTH-2:0], ge};
    quot_fin = sign_q ? -q_next : q_next;
    rem_fin  = sign_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      divisor   <= '0;
      dividend  <= '0;
      rem_p     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quot_r    <= '0;
      rem_r     <= '0;
      data_ok_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_ok_r <= 1'b0;
          if (bus.valid) begin
            divisor  <= b_mag;
            dividend <= a_mag;
            rem_p    <= '0;
            cnt      <= '0;
            sign_q   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r   <= bus.is_signed & bus.a[WIDTH-1];
            if (bus.b == '0) begin
              quot_r    <= '1;
              rem_r     <= bus.a;
              data_ok_r <= 1'b1;
              state     <= DONE;
            end else begin
              busy_r <= 1'b1;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!bus.valid) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            dividend <= q_next;
            rem_p    <= rem_next;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              quot_r    <= quot_fin;
              rem_r     <= rem_fin;
              busy_r    <= 1'b0;
              data_ok_r <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          data_ok_r <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          data_ok_r <= 1'b0;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_ok = data_ok_r;
  assign bus.busy    = busy_r;
  assign bus.quot    = quot_r;
  assign bus.rem     = rem_r;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands compared against a plain-arithmetic reference.
module tb_seq_divider;
  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_ok = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.data_ok === 1'b1) n_ok++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a == MINV && sb == -1) begin
        q = MINV;
        r = '0;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_done(output int cyc, output logic busy_first);
    cyc = 0;
    busy_first = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy_first = bus.busy;
      if (bus.data_ok === 1'b1) break;
    end
  endtask

  // Caller is at a negedge. With hold=1 valid stays high after data_ok.
  task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit hold);
    logic [W-1:0] eq, er;
    int   cyc, ok0;
    logic bf;
    ref_div(sgn, a, b, eq, er);
    ok0 = n_ok;
    bus.valid = 1'b1;
    bus.is_signed = sgn;
    bus.a = a;
    bus.b = b;
    wait_done(cyc, bf);
    chk({tag, "_lat"}, W'(cyc), (b == '0) ? W'(1) : W'(W + 1));
    chk({tag, "_quot"}, bus.quot, eq);
    chk({tag, "_rem"}, bus.rem, er);
    if (b != '0) chk({tag, "_busy"}, W'(bf), W'(1));
    last_q = eq;
    last_r = er;
    if (!hold) begin
      bus.valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_okdrop"}, W'(bus.data_ok), W'(0));
      chk({tag, "_npulse"}, W'(n_ok - ok0), W'(1));
    end
  endtask

  initial begin
    int cyc, ok0;
    logic bf;
    logic [W-1:0] ra, rb;
    logic rs;

    bus.valid = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("rst_quot", bus.quot, '0);
    chk("rst_rem", bus.rem, '0);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_ok", W'(bus.data_ok), '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    do_op("u100_7", 1'b0, W'(100), W'(7), 1'b0);
    do_op("s-100_7", 1'b1, -W'(100), W'(7), 1'b0);
    do_op("s100_-7", 1'b1, W'(100), -W'(7), 1'b0);
    do_op("div0", 1'b0, W'('h1234), '0, 1'b0);
    do_op("sdiv0", 1'b1, -W'(5), '0, 1'b0);
    do_op("s_ovf", 1'b1, MINV, '1, 1'b0);
    do_op("u_ovf", 1'b0, MINV, '1, 1'b0);

    // abort mid-BUSY by dropping valid
    ok0 = n_ok;
    bus.valid = 1'b1;
    bus.is_signed = 1'b0;
    bus.a = W'(1000);
    bus.b = W'(3);
    repeat (11) @(negedge clk);
    chk("abort_busy_before", W'(bus.busy), W'(1));
    bus.valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_ok", W'(bus.data_ok), W'(0));
    repeat (70) @(negedge clk);
    chk("abort_quot", bus.quot, last_q);
    chk("abort_rem", bus.rem, last_r);
    chk("abort_npulse", W'(n_ok - ok0), W'(0));
    do_op("u9_3", 1'b0, W'(9), W'(3), 1'b0);

    // valid held through data_ok, then new operands
    ok0 = n_ok;
    do_op("hold1", 1'b0, W'(100), W'(7), 1'b1);
    bus.a = '1;
    bus.b = W'(2);
    wait_done(cyc, bf);
    chk("hold2_ignore_busy", W'(bf), W'(0));
    chk("hold2_lat", W'(cyc), W'(W + 2));
    chk("hold2_quot", bus.quot, {1'b0, {(W-1){1'b1}}});
    chk("hold2_rem", bus.rem, W'(1));
    bus.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hold_npulse", W'(n_ok - ok0), W'(2));

    // random operands
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom} >> $urandom_range(0, 60);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      case ($urandom_range(0, 3))
        0: rb = {$urandom, $urandom} >> $urandom_range(0, 62);
        1: rb = W'($urandom_range(1, 20));
        2: rb = -W'($urandom_range(1, 20));
        default: rb = ($urandom_range(0, 1) == 1) ? '0 : '1;
      endcase
      do_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b0);
    end

    // async reset mid-BUSY
    ok0 = n_ok;
    bus.valid = 1'b1;
    bus.is_signed = 1'b1;
    bus.a = W'(77);
    bus.b = W'(5);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rstmid_quot", bus.quot, '0);
    chk("rstmid_rem", bus.rem, '0);
    chk("rstmid_busy", W'(bus.busy), '0);
    bus.valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (80) @(negedge clk);
    chk("rstmid_npulse", W'(n_ok - ok0), W'(0));
    chk("rstmid_ok", W'(bus.data_ok), W'(0));
    do_op("post_rst", 1'b1, -W'(77), W'(5), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
